fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Y86-64 pipeline fetch stage: owns the F-register predicted PC, selects the fetch PC and reads the instruction bytes.
- Splits and aligns each instruction and raises status flags.
- Drives the f_* bus and the hlt / imem_err / instr_valid flags consumed by the D pipeline register directly downstream.
- Adds a sticky post-halt quiesce latch so fetch stops walking memory after a terminal instruction until a redirect arrives.

Parameters:
- RESET_PC, 64'h0, predicted PC loaded on reset.
- IMEM_BYTES, 1024, instruction memory size in bytes; fetch address + instruction length > IMEM_BYTES gives an address error.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- F_stall  in  1  hold F_predPC and the halt latch this cycle
- M_icode  in  4  memory-stage icode, for mispredict recovery
- M_Cnd  in  1  memory-stage branch condition
- M_valA  in  64  fall-through PC of a mispredicted jXX
- W_icode  in  4  writeback-stage icode, for ret recovery
- W_valM  in  64  return address popped by ret
- imem_addr  out  64  fetch PC, combinational
- imem_rdata  in  80  10 bytes at imem_addr, little-endian; bits [7:0] are the byte at imem_addr
- f_icode, f_ifun, f_rA, f_rB  out  4 each  split instruction fields
- f_valC  out  64  constant word
- f_valP  out  64  PC + instruction length
- f_stat  out  4  status: 1 AOK, 2 HLT, 3 ADR, 4 INS
- hlt  out  1  fetched icode is 0
- imem_err  out  1  address error
- instr_valid  out  1  HIGH means INVALID icode/ifun; polarity is fixed by the D-register consumer
- F_predPC  out  64  registered predicted PC

Behaviour:
- PC select, combinational, priority order:
  - M_icode==7 && !M_Cnd → M_valA
  - else W_icode==9 → W_valM
  - else F_predPC
- imem_addr = selected PC.
- Byte split: byte0 = {icode[7:4], ifun[3:0]}; byte1 = {rA[7:4], rB[3:0]}.
- need_regids when icode ∈ {2,3,4,5,6,A,B}; otherwise f_rA = f_rB = 4'hF.
- need_valC when icode ∈ {3,4,5,7,8}: f_valC = bytes 2..9 if need_regids, else bytes 1..8, little-endian; otherwise f_valC = 0.
- f_valP = PC + 1 + need_regids + 8·need_valC; 64-bit, wraps modulo 2^64.
- Invalid instruction, any of:
  - icode > B
  - icode 2 with ifun > 6
  - icode 6 with ifun > 3
  - icode 7 with ifun > 6
  - any other icode with ifun ≠ 0
- imem_err when PC + length > IMEM_BYTES (compare in 65-bit arithmetic) or PC wraps.
- On imem_err: f_icode = 1 (nop), f_ifun = 0.
- f_stat precedence: ADR > INS > HLT > AOK. Flags are raised independently; hlt / instr_valid are suppressed when imem_err is set.
- Predicted next PC = f_valC for icode 7 or 8, else f_valP.
- F_predPC register:
  - rst → RESET_PC.
  - Else if !F_stall → predicted next PC.
  - Else hold.
- Halt latch halted_q:
  - rst → 0.
  - Set on a non-stalled cycle whose f_stat ≠ AOK.
  - Cleared on any cycle with a redirect (the M or W select arm active), whether or not stalled.
  - While halted_q && no redirect: outputs are f_icode = 1, f_ifun = 0, f_stat = 1, flags 0; F_predPC holds; imem_addr still driven.
- Simultaneous events:
  - Redirect beats halted_q.
  - F_stall beats both the set and the update; the redirect still clears the latch.
- Reset mid-instruction: next cycle fetches RESET_PC with all state cleared.
- Outputs are combinational from F_predPC / halted_q / imem_rdata; latency to the D register is 1 clk.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt [31:0] and stall_cnt [31:0].
  - Both reset to 0.
  - fetch_cnt increments on each non-stalled, non-halted cycle.
  - stall_cnt increments on each F_stall cycle.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package y86_pkg:
  - icode constants (IHALT=0 … IPOPQ=B)
  - stat codes SAOK / SHLT / SADR / SINS
  - RNONE = 4'hF
  - an instr_len function
- One sub-module, fetch_align: purely combinational split / align / valid-check from byte array and PC to fields, valC, valP and flags.
- The PC-select mux, registers and halt latch stay in the top.

Test Plan:
- Reset, then irmovq (30 F3 + 8-byte constant 0x0123456789ABCDEF) at PC 0:
  - f_rA = F, f_rB = 3, f_valC = 0x0123456789ABCDEF, f_valP = 10.
  - F_predPC = 10 the next clk.
- jXX at PC 0x20 with valC = 0x100: F_predPC becomes 0x100. Then drive M_icode = 7, M_Cnd = 0, M_valA = 0x29: imem_addr = 0x29 the same cycle, W_icode = 9 ignored.
- ret recovery: W_icode = 9, W_valM = 0x40 → imem_addr = 0x40. Repeat with F_stall = 1 → F_predPC holds its old value.
- Byte 0x00 at PC 0x50:
  - hlt = 1, f_stat = 2.
  - Following cycles output nop with stat 1 and F_predPC frozen.
  - A redirect to 0x60 resumes fetch at 0x60.
- Invalid fetches:
  - Byte 0x65 → instr_valid = 1, f_stat = 4.
  - Byte 0xC0 → instr_valid = 1.
  - PC = IMEM_BYTES−2 with irmovq → imem_err = 1, f_stat = 3, f_icode = 1.
- FETCH_PERF_CNT_EN defined: 5 fetches, then 3 stalls → fetch_cnt = 5, stall_cnt = 3. Assert rst mid-stream → both counters read 0 the next cycle.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode constants, status codes, the fetch
// bus struct and instruction-length helpers used by the fetch stage.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  // Decoded fetch result handed from the aligner to the top.
  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] pred;
    logic [3:0]  stat;
    logic        hlt;
    logic        adr_err;
    logic        invalid;
  } fetch_bus_t;

  function automatic logic need_regids(input logic [3:0] icode);
    return icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
  endfunction

  function automatic logic need_valc(input logic [3:0] icode);
    return icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
  endfunction

  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    return 4'd1 + {3'd0, need_regids(icode)} + (need_valc(icode) ? 4'd8 : 4'd0);
  endfunction

endpackage

// File: rtl/fetch_align.sv
// Combinational instruction splitter / aligner.
// Ports: pc (fetch PC), bytes (10 little-endian bytes at pc) -> fb, the
// decoded fields, constant word, next PC, predicted PC, status and flags.
// An address error forces the icode/ifun pair to a nop.
module fetch_align
  import y86_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic [63:0]     pc,
  input  logic [9:0][7:0] bytes,
  output fetch_bus_t      fb
);

  logic [3:0]  icode, ifun;
  logic        regids, valc_en, invalid, adr_err;
  logic [64:0] end_addr;
  logic [63:0] valc;

  assign icode    = bytes[0][7:4];
  assign ifun     = bytes[0][3:0];
  assign regids   = need_regids(icode);
  assign valc_en  = need_valc(icode);
  // 65-bit so a fetch that wraps past 2^64 is still caught.
  assign end_addr = {1'b0, pc} + {61'd0, instr_len(icode)};
  assign adr_err  = (end_addr > 65'(IMEM_BYTES)) || end_addr[64];

  always_comb begin
    invalid = 1'b0;
    case (icode)
      IRRMOVQ, IJXX: invalid = (ifun > 4'd6);
      IOPQ:          invalid = (ifun > 4'd3);
      default:       invalid = (icode > IPOPQ) || (ifun != 4'd0);
    endcase
  end

  always_comb begin
    valc = 64'd0;
    if (valc_en) valc = regids ? bytes[9:2] : bytes[8:1];
  end

  always_comb begin
    fb.icode   = adr_err ? INOP : icode;
    fb.ifun    = adr_err ? 4'd0 : ifun;
    fb.ra      = regids ? bytes[1][7:4] : RNONE;
    fb.rb      = regids ? bytes[1][3:0] : RNONE;
    fb.valc    = valc;
    fb.valp    = end_addr[63:0];
    fb.pred    = (icode == IJXX || icode == ICALL) ? valc : end_addr[63:0];
    fb.adr_err = adr_err;
    fb.invalid = invalid && !adr_err;
    fb.hlt     = (icode == IHALT) && !adr_err;
    if (adr_err)             fb.stat = SADR;
    else if (invalid)        fb.stat = SINS;
    else if (icode == IHALT) fb.stat = SHLT;
    else                     fb.stat = SAOK;
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, predicted-PC register, post-halt quiesce
// latch and the f_* bus to the D register.
// Ports: clk/rst (sync, active high); F_stall; M_* / W_* redirect sources;
// imem_addr/imem_rdata instruction memory; f_* fields, hlt, imem_err,
// instr_valid (high = invalid), F_predPC.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch_cnt / stall_cnt.
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  output logic [63:0] imem_addr,
  input  logic [79:0] imem_rdata,
  output logic [3:0]  f_icode,
  output logic [3:0]  f_ifun,
  output logic [3:0]  f_rA,
  output logic [3:0]  f_rB,
  output logic [63:0] f_valC,
  output logic [63:0] f_valP,
  output logic [3:0]  f_stat,
  output logic        hlt,
  output logic        imem_err,
  output logic        instr_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic [63:0] F_predPC
);

  logic       m_redir, w_redir, redirect, halted_q, quiesce;
  fetch_bus_t fb;

  assign m_redir  = (M_icode == IJXX) && !M_Cnd;
  assign w_redir  = (W_icode == IRET);
  assign redirect = m_redir || w_redir;
  // A redirect leaves the halted path, so it overrides the latch at once.
  assign quiesce  = halted_q && !redirect;

  always_comb begin
    imem_addr = F_predPC;
    if (m_redir)      imem_addr = M_valA;
    else if (w_redir) imem_addr = W_valM;
  end

  fetch_align #(.IMEM_BYTES(IMEM_BYTES)) u_align (
    .pc    (imem_addr),
    .bytes (imem_rdata),
    .fb    (fb)
  );

  always_comb begin
    f_icode     = fb.icode;
    f_ifun      = fb.ifun;
    f_rA        = fb.ra;
    f_rB        = fb.rb;
    f_valC      = fb.valc;
    f_valP      = fb.valp;
    f_stat      = fb.stat;
    hlt         = fb.hlt;
    imem_err    = fb.adr_err;
    instr_valid = fb.invalid;
    if (quiesce) begin
      f_icode     = INOP;
      f_ifun      = 4'd0;
      f_rA        = RNONE;
      f_rB        = RNONE;
      f_valC      = 64'd0;
      f_stat      = SAOK;
      hlt         = 1'b0;
      imem_err    = 1'b0;
      instr_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      F_predPC <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      if (!F_stall && !quiesce) F_predPC <= fb.pred;
      if (redirect)                         halted_q <= 1'b0;
      else if (!F_stall && f_stat != SAOK)  halted_q <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (!F_stall && !quiesce && fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
      if (F_stall && stall_cnt != 32'hFFFF_FFFF)             stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, F_stall, M_Cnd;
  logic [3:0]  M_icode, W_icode;
  logic [63:0] M_valA, W_valM, imem_addr, f_valC, f_valP, F_predPC;
  logic [79:0] imem_rdata;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB, f_stat;
  logic        hlt, imem_err, instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif
  logic [7:0]  mem [0:1023];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(64'h0), .IMEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .F_stall(F_stall),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat),
    .hlt(hlt), .imem_err(imem_err), .instr_valid(instr_valid),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
    .F_predPC(F_predPC)
  );

  // Memory model: bytes beyond the array read as zero.
  always_comb begin
    imem_rdata = 80'd0;
    for (int i = 0; i < 10; i++) begin
      if (imem_addr + 64'(i) < 64'd1024) imem_rdata[i*8 +: 8] = mem[imem_addr + 64'(i)];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int a, input logic [7:0] b);
    mem[a] = b;
  endtask

  task automatic put_q(input int a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) mem[a+i] = v[i*8 +: 8];
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    put(0, 8'h30); put(1, 8'hF3); put_q(2, 64'h0123456789ABCDEF);  // irmovq
    put(10, 8'h70); put_q(11, 64'h20);                             // jmp 0x20
    put(32, 8'h73); put_q(33, 64'h100);                            // je 0x100
    put(41, 8'h10);                                                // nop @0x29
    put(42, 8'h70); put_q(43, 64'h50);                             // jmp 0x50 @0x2A
    put(96, 8'h20); put(97, 8'h12);                                // rrmovq @0x60
    put(98, 8'h65);                                                // bad opq @0x62
    put(112, 8'hC0);                                               // bad icode @0x70
    for (int i = 128; i < 144; i++) mem[i] = 8'h10;                // nops @0x80
    put(1014, 8'h30); put(1015, 8'hF3); put_q(1016, 64'hF330665544332211);

    rst = 1; F_stall = 0; M_icode = 0; M_Cnd = 0; M_valA = 0; W_icode = 0; W_valM = 0;
    step();
    rst = 0; #1;
    chk("reset_predpc", F_predPC, 64'h0);
    chk("reset_addr", imem_addr, 64'h0);
    chk("irmov_icode", f_icode, 4'h3);
    chk("irmov_ra", f_rA, 4'hF);
    chk("irmov_rb", f_rB, 4'h3);
    chk("irmov_valc", f_valC, 64'h0123456789ABCDEF);
    chk("irmov_valp", f_valP, 64'd10);
    chk("irmov_stat", f_stat, 4'h1);
    step();
    chk("predpc_10", F_predPC, 64'd10);
    chk("jmp_valc", f_valC, 64'h20);
    chk("jmp_rb_none", f_rB, 4'hF);
    step();
    chk("predpc_20", F_predPC, 64'h20);
    chk("jxx_valp", f_valP, 64'h29);
    step();
    chk("predpc_100", F_predPC, 64'h100);

    // Mispredict has priority over ret
    M_icode = 7; M_Cnd = 0; M_valA = 64'h29; W_icode = 9; W_valM = 64'h40; #1;
    chk("m_redirect_addr", imem_addr, 64'h29);
    chk("m_redirect_icode", f_icode, 4'h1);
    step();
    chk("predpc_after_m", F_predPC, 64'h2A);
    M_icode = 0; #1;
    chk("w_redirect_addr", imem_addr, 64'h40);
    F_stall = 1;
    step();
    chk("stall_holds_pc", F_predPC, 64'h2A);
    F_stall = 0; W_icode = 0; #1;
    chk("jmp50_addr", imem_addr, 64'h2A);
    step();
    chk("predpc_50", F_predPC, 64'h50);
    chk("halt_hlt", hlt, 1'b1);
    chk("halt_stat", f_stat, 4'h2);
    chk("halt_iv", instr_valid, 1'b0);
    step();
    chk("halted_predpc", F_predPC, 64'h51);
    chk("halted_icode", f_icode, 4'h1);
    chk("halted_stat", f_stat, 4'h1);
    chk("halted_hlt", hlt, 1'b0);
    chk("halted_addr", imem_addr, 64'h51);
    step();
    chk("halted_frozen", F_predPC, 64'h51);

    M_icode = 7; M_Cnd = 0; M_valA = 64'h60; #1;
    chk("resume_addr", imem_addr, 64'h60);
    chk("resume_icode", f_icode, 4'h2);
    chk("resume_ra", f_rA, 4'h1);
    step();
    M_icode = 0; #1;
    chk("resume_predpc", F_predPC, 64'h62);
    chk("bad_ifun_iv", instr_valid, 1'b1);
    chk("bad_ifun_stat", f_stat, 4'h4);
    step();
    chk("ins_frozen_pc", F_predPC, 64'h64);
    chk("ins_quiesced", instr_valid, 1'b0);

    W_icode = 9; W_valM = 64'h70; #1;
    chk("bad_icode_iv", instr_valid, 1'b1);
    chk("bad_icode_stat", f_stat, 4'h4);
    W_valM = 64'd1014; #1;
    chk("edge_fit_err", imem_err, 1'b0);
    chk("edge_fit_valc", f_valC, 64'hF330665544332211);
    chk("edge_fit_valp", f_valP, 64'd1024);
    W_valM = 64'd1022; #1;
    chk("adr_err", imem_err, 1'b1);
    chk("adr_stat", f_stat, 4'h3);
    chk("adr_icode", f_icode, 4'h1);
    chk("adr_ifun", f_ifun, 4'h0);
    W_valM = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    chk("wrap_err", imem_err, 1'b1);
    chk("wrap_hlt_suppressed", hlt, 1'b0);
    step();

    rst = 1; W_icode = 0;
    step();
    rst = 0; #1;
    chk("midreset_predpc", F_predPC, 64'h0);
    chk("midreset_icode", f_icode, 4'h3);

`ifdef FETCH_PERF_CNT_EN
    chk("cnt_reset_fetch", fetch_cnt, 32'd0);
    chk("cnt_reset_stall", stall_cnt, 32'd0);
    W_icode = 9; W_valM = 64'h80;
    step();
    W_icode = 0;
    for (int i = 0; i < 4; i++) step();
    chk("fetch_cnt_5", fetch_cnt, 32'd5);
    F_stall = 1;
    for (int i = 0; i < 3; i++) step();
    chk("stall_cnt_3", stall_cnt, 32'd3);
    chk("fetch_cnt_held", fetch_cnt, 32'd5);
    F_stall = 0; rst = 1;
    step();
    chk("cnt_rst_fetch", fetch_cnt, 32'd0);
    chk("cnt_rst_stall", stall_cnt, 32'd0);
    rst = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
